// File: rtl/uart_rx.sv
// 16550-style UART receiver: oversampled start detection, mid-bit sampling,
// 5..8 data bits LSB-first, optional parity, one checked stop bit.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       tick,
  input  logic [3:0] data_bits,
  input  logic       parity_en,
  input  logic       parity_even,
  output logic       enable_baud,
  output logic       rx_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       break_det
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_d;
  logic [CNT_W-1:0]       tick_cnt;
  logic [2:0]             bit_idx;
  logic [3:0]             len_q;
  logic                   par_en_q, par_even_q, par_acc, any_one;
  logic [7:0]             shreg;
  logic                   start_edge, samp, last_bit;

  function automatic logic [3:0] clamp_len(input logic [3:0] n);
    if (n < 4'd5) return 4'd5;
    if (n > 4'd8) return 4'd8;
    return n;
  endfunction

  // Stage: rxd synchronizer and edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxs_d  <= rxs;
    end
  end

  assign rxs        = sync_q[SYNC_STAGES-1];
  assign start_edge = ~rxs & rxs_d;
  // START samples half a bit in; every later state samples a full bit after the last sample
  assign samp       = tick && ((state == START) ? (tick_cnt == CNT_HALF)
                                                : (state != IDLE && tick_cnt == CNT_LAST));
  assign last_bit   = ({1'b0, bit_idx} == (len_q - 4'd1));

  // Stage: frame state machine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = START;
      START:   if (samp) state_nxt = rxs ? IDLE : DATA;
      DATA:    if (samp && last_bit) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (samp) state_nxt = STOP;
      STOP:    if (samp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage: bit capture and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt    <= '0;
      bit_idx     <= '0;
      len_q       <= 4'd8;
      par_en_q    <= 1'b0;
      par_even_q  <= 1'b0;
      par_acc     <= 1'b0;
      any_one     <= 1'b0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE) begin
        if (start_edge) begin
          tick_cnt   <= '0;
          bit_idx    <= '0;
          len_q      <= clamp_len(data_bits);
          par_en_q   <= parity_en;
          par_even_q <= parity_even;
          par_acc    <= 1'b0;
          any_one    <= 1'b0;
          shreg      <= '0;
        end
      end else if (tick) begin
        tick_cnt <= samp ? '0 : tick_cnt + 1'b1;
      end

      if (samp) begin
        case (state)
          DATA: begin
            shreg[bit_idx] <= rxs;
            par_acc        <= par_acc ^ rxs;
            any_one        <= any_one | rxs;
            bit_idx        <= bit_idx + 3'd1;
          end
          PARITY: begin
            par_acc <= par_acc ^ rxs;
            any_one <= any_one | rxs;
          end
          STOP: begin
            rx_valid    <= 1'b1;
            rx_data     <= shreg;
            parity_err  <= par_en_q & (par_acc ^ ~par_even_q);
            framing_err <= ~rxs;
            break_det   <= ~any_one & ~rxs;
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_busy     = (state != IDLE);
  assign enable_baud = rx_busy;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the 16550-compatible UART; the counterpart of the transmitter.
- Oversamples `rxd` using the baud generator's tick, detects a start bit, and samples each bit at its midpoint.
- Assembles 5–8 data bits LSB-first, checks optional parity and the stop bit, and presents one byte per frame with error flags.
- Feeds the RX FIFO / line-status logic; requests the baud generator only while a frame is in progress.

Parameters:
- OVERSAMPLE, 16, tick pulses per bit period (even, ≥4).
- SYNC_STAGES, 2, flip-flop stages in the `rxd` synchronizer (≥2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset (block in reset while 0)
- rxd  input  1  serial input, asynchronous to clk, idle high
- tick  input  1  one-clk pulse at OVERSAMPLE × baud, valid while enable_baud=1
- data_bits  input  4  word length 5..8; values <5 act as 5, >8 act as 8
- parity_en  input  1  parity bit present
- parity_even  input  1  1 = even parity, 0 = odd
- enable_baud  output  1  requests tick generation
- rx_busy  output  1  frame in progress
- rx_data  output  8  received word, right-justified, unused upper bits 0
- rx_valid  output  1  one-clk pulse: rx_data and flags valid
- parity_err  output  1  parity mismatch (valid with rx_valid)
- framing_err  output  1  first stop bit sampled 0 (valid with rx_valid)
- break_det  output  1  all data, parity and stop samples 0 (valid with rx_valid)

Behaviour:
- **Reset (rst=0, async):**
  - Synchronizer flops → 1; state → IDLE.
  - All outputs → 0; rx_data → 8'h00.
  - Takes effect immediately, including mid-frame; no partial frame is ever reported.
- **Synchronizer:** `rxd` passes through SYNC_STAGES flops; `rxs` is the last stage. `rxs_d` is `rxs` delayed one clk.
- **State machine:** IDLE, START, DATA, PARITY, STOP. rx_busy = enable_baud = (state ≠ IDLE).
- **IDLE:**
  - Enter START when rxs=0 and rxs_d=1 (falling edge).
  - On entry: clear the tick counter; latch data_bits, parity_en and parity_even. Config changes mid-frame are ignored.
  - A line held low never re-triggers; a falling edge is required.
- **Tick counter:** counts tick pulses only; clk cycles without tick do nothing.
- **START:**
  - On the (OVERSAMPLE/2)th tick, sample rxs.
  - rxs=1: false start; return to IDLE, no rx_valid.
  - rxs=0: clear the counter, go to DATA.
- **DATA:**
  - On every OVERSAMPLE-th tick, sample rxs into bit position `bit_idx` (LSB first) and XOR it into the running parity.
  - After the latched word-length samples: go to PARITY if parity_en, else STOP.
- **PARITY:**
  - On the OVERSAMPLE-th tick, sample and go to STOP.
  - parity_err = (XOR of data bits ^ parity sample) ≠ (parity_even ? 0 : 1).
- **STOP:**
  - On the OVERSAMPLE-th tick, sample rxs.
  - framing_err = ~sample.
  - break_det = 1 when every sampled bit including stop is 0 and rx_data == 0.
  - Only the first stop bit is checked; extra stop bits look like idle.
- **Frame completion:**
  - The clk after the stop-sample tick: rx_valid=1 for exactly one clk; rx_data and flags updated in that same clk; state → IDLE.
  - rx_data and flags hold their values until the next rx_valid.
- **Restart after errors:** after a framing error or break, the next start still requires a falling edge, so a held-low line gives exactly one report.
- **Latency:** rx_valid arrives (OVERSAMPLE/2 + N·OVERSAMPLE) ticks after start detection, plus 1 clk, where N = data bits + parity + 1 stop.
- **Parity disabled:** parity_err = 0.
- **Width:** rx_data is shifted into the position given by the latched word length; bits [7:len] are forced to 0.

Test Plan:
- **8N1, 0xA5:** tick every 4 clk; drive a clean frame. → One rx_valid, rx_data=8'hA5, all flags 0, enable_baud low again after the pulse.
- **7E1 and 5O1:**
  - 7E1, data 7'h41, correct parity bit 0 → rx_data=8'h41, parity_err=0.
  - Same frame with parity bit flipped → parity_err=1.
  - 5O1, 5'h1F → rx_data=8'h1F.
- **Glitch:** 3-tick low pulse on idle line. → Returns to IDLE, no rx_valid, enable_baud drops.
- **Framing error and break:**
  - 8N1, 0x55 with stop=0 → framing_err=1, break_det=0.
  - Line held low for 3 frame times → exactly one rx_valid with rx_data=0, framing_err=1, break_det=1; the next valid frame after line high is received correctly.
- **Mid-frame disruption:**
  - Assert rst during DATA → all outputs 0 immediately, no rx_valid.
  - Change data_bits 8→5 mid-frame → the frame completes as 8 bits.
- **Back-to-back:** 0x00, 0xFF, 0x3C with a single stop bit and no gap → three rx_valid pulses with correct data.
